// File: rtl/mbox_req_seq.sv
// mbox_req_seq: captures a VMA memory cycle and runs it locally (fast memory) or through the MBOX handshake
module mbox_req_seq #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        START,
  input  logic        REQ_READ,
  input  logic        REQ_WRITE,
  input  logic        REQ_FETCH,
  input  logic [22:0] VMA,
  input  logic        AC_REF,
  input  logic        MATCH,
  input  logic [2:0]  BRK_COND,
  input  logic        MBOX_ACK,
  input  logic        MBOX_DATA_OK,
  input  logic        MBOX_PF,
  output logic        MBOX_REQ,
  output logic [22:0] MBOX_ADDR,
  output logic        MBOX_RD,
  output logic        MBOX_WR,
  output logic        FM_REF,
  output logic        BUSY,
  output logic        MEM_DONE,
  output logic        PAGE_FAIL,
  output logic        NXM,
  output logic        ADR_BRK_TRAP
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, BRK, FM, REQ, WAIT, DONE, PF, TMO} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic rd_cap, wr_cap, rd_n, wr_n;
  logic accept, brk, tmo_hit;
  logic req_d, rd_d, wr_d, fm_d, busy_d, done_d, pf_d, nxm_d, trap_d;
  assign accept  = START & (REQ_READ | REQ_WRITE) & (state == IDLE);
  assign brk     = MATCH & ((BRK_COND[2] & REQ_FETCH) | (BRK_COND[1] & REQ_READ) | (BRK_COND[0] & REQ_WRITE));
  assign tmo_hit = cnt == CW'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clk)
    state <= RESET ? IDLE : state_n;
  // next state: address break beats fast memory beats MBOX; page fail beats data beats timeout
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = !accept ? IDLE : brk ? BRK : AC_REF ? FM : REQ;
      FM:      state_n = DONE;
      REQ:     state_n = MBOX_ACK ? WAIT : REQ;
      WAIT:    state_n = MBOX_PF ? PF : MBOX_DATA_OK ? DONE : tmo_hit ? TMO : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // outputs decoded from the next state so the registered copies line up with the state
  always_comb begin
    rd_n   = accept ? REQ_READ : rd_cap;
    wr_n   = accept ? REQ_WRITE : wr_cap;
    req_d  = state_n == REQ;
    rd_d   = req_d & rd_n;
    wr_d   = req_d & wr_n;
    fm_d   = state_n == FM;
    busy_d = state_n != IDLE;
    done_d = state_n == DONE;
    pf_d   = state_n == PF;
    nxm_d  = state_n == TMO;
    trap_d = state_n == BRK;
  end
  // registered outputs and captured cycle qualifiers
  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_cap       <= 1'b0;
      wr_cap       <= 1'b0;
      MBOX_ADDR    <= '0;
      MBOX_REQ     <= 1'b0;
      MBOX_RD      <= 1'b0;
      MBOX_WR      <= 1'b0;
      FM_REF       <= 1'b0;
      BUSY         <= 1'b0;
      MEM_DONE     <= 1'b0;
      PAGE_FAIL    <= 1'b0;
      NXM          <= 1'b0;
      ADR_BRK_TRAP <= 1'b0;
    end else begin
      rd_cap       <= rd_n;
      wr_cap       <= wr_n;
      MBOX_ADDR    <= accept ? VMA : MBOX_ADDR;
      MBOX_REQ     <= req_d;
      MBOX_RD      <= rd_d;
      MBOX_WR      <= wr_d;
      FM_REF       <= fm_d;
      BUSY         <= busy_d;
      MEM_DONE     <= done_d;
      PAGE_FAIL    <= pf_d;
      NXM          <= nxm_d;
      ADR_BRK_TRAP <= trap_d;
    end
  end
  // response timer: zero outside WAIT so it starts from 0 on WAIT entry, saturating inside
  always_ff @(posedge clk)
    cnt <= (RESET || state != WAIT) ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
endmodule

// File: tb/tb_mbox_req_seq.sv
// tb_mbox_req_seq: scoreboarded check of result pulses plus direct handshake checks
module tb_mbox_req_seq;
  logic clk = 1'b0, RESET = 1'b1, START = 1'b0, REQ_READ = 1'b0, REQ_WRITE = 1'b0, REQ_FETCH = 1'b0;
  logic [22:0] VMA = '0;
  logic AC_REF = 1'b0, MATCH = 1'b0;
  logic [2:0] BRK_COND = '0;
  logic MBOX_ACK = 1'b0, MBOX_DATA_OK = 1'b0, MBOX_PF = 1'b0;
  logic MBOX_REQ, MBOX_RD, MBOX_WR, FM_REF, BUSY, MEM_DONE, PAGE_FAIL, NXM, ADR_BRK_TRAP;
  logic [22:0] MBOX_ADDR;
  typedef struct {int c; logic [4:0] k;} ev_t;
  localparam logic [4:0] K_TRAP = 5'b10000, K_FM = 5'b01000, K_DONE = 5'b00100, K_PF = 5'b00010, K_NXM = 5'b00001;
  ev_t q[$];
  ev_t e;
  logic [4:0] p;
  int cyc = 0, checks = 0, errors = 0, c0;
  mbox_req_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .RESET(RESET), .START(START), .REQ_READ(REQ_READ), .REQ_WRITE(REQ_WRITE),
    .REQ_FETCH(REQ_FETCH), .VMA(VMA), .AC_REF(AC_REF), .MATCH(MATCH), .BRK_COND(BRK_COND),
    .MBOX_ACK(MBOX_ACK), .MBOX_DATA_OK(MBOX_DATA_OK), .MBOX_PF(MBOX_PF), .MBOX_REQ(MBOX_REQ),
    .MBOX_ADDR(MBOX_ADDR), .MBOX_RD(MBOX_RD), .MBOX_WR(MBOX_WR), .FM_REF(FM_REF), .BUSY(BUSY),
    .MEM_DONE(MEM_DONE), .PAGE_FAIL(PAGE_FAIL), .NXM(NXM), .ADR_BRK_TRAP(ADR_BRK_TRAP)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic rd, input logic wr, input logic [22:0] a, input logic ac);
    START = 1'b1; REQ_READ = rd; REQ_WRITE = wr; VMA = a; AC_REF = ac;
    c0 = cyc;
  endtask
  task automatic idle_in();
    START = 1'b0; REQ_READ = 1'b0; REQ_WRITE = 1'b0; REQ_FETCH = 1'b0; AC_REF = 1'b0; MATCH = 1'b0;
  endtask
  // pulse monitor: every result pulse must match the oldest expected event
  always @(negedge clk) if (cyc > 2) begin
    p = {ADR_BRK_TRAP, FM_REF, MEM_DONE, PAGE_FAIL, NXM};
    while (q.size() > 0 && q[0].c < cyc) begin
      e = q.pop_front();
      chk("missed_pulse", 32'(e.k), 0);
    end
    if (p != 0) begin
      if (q.size() == 0) chk("unexpected_pulse", 32'(p), 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind", 32'(p), 32'(e.k));
        chk("pulse_cycle", cyc, e.c);
      end
    end
  end
  initial begin
    step(3);
    RESET = 1'b0;
    chk("rst_req", 32'(MBOX_REQ), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_addr", 32'(MBOX_ADDR), 0);
    chk("rst_pulses", 32'({FM_REF, MEM_DONE, PAGE_FAIL, NXM, ADR_BRK_TRAP}), 0);
    step;
    // MBOX read: ack at +3, data at +6
    go(1, 0, 23'o0001234, 0);
    q.push_back('{c0 + 7, K_DONE});
    step; idle_in();
    chk("t1_req1", 32'(MBOX_REQ), 1);
    chk("t1_addr", 32'(MBOX_ADDR), 32'(23'o0001234));
    chk("t1_rd", 32'(MBOX_RD), 1);
    chk("t1_wr", 32'(MBOX_WR), 0);
    chk("t1_busy", 32'(BUSY), 1);
    step; chk("t1_req2", 32'(MBOX_REQ), 1);
    step; chk("t1_req3", 32'(MBOX_REQ), 1); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0; chk("t1_req_drop", 32'(MBOX_REQ), 0);
    step(2); MBOX_DATA_OK = 1'b1;
    step; MBOX_DATA_OK = 1'b0; chk("t1_busy_pulse", 32'(BUSY), 1);
    step; chk("t1_busy_end", 32'(BUSY), 0);
    // fast memory write; START during the done pulse is ignored
    go(0, 1, 23'o0000017, 1);
    q.push_back('{c0 + 1, K_FM});
    q.push_back('{c0 + 2, K_DONE});
    step; idle_in(); chk("t2_req1", 32'(MBOX_REQ), 0);
    step; chk("t2_req2", 32'(MBOX_REQ), 0);
    go(1, 0, 23'o0000020, 1);
    step; idle_in(); chk("t2_busy_ignored", 32'(BUSY), 0);
    // START with neither read nor write is ignored
    go(0, 0, 23'o0000021, 0);
    step; idle_in(); chk("nop_busy", 32'(BUSY), 0);
    chk("nop_addr", 32'(MBOX_ADDR), 32'(23'o0000017));
    // timeout: ack at +1, no response
    go(1, 0, 23'o0000100, 0);
    q.push_back('{c0 + 6, K_NXM});
    step; idle_in(); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0; chk("t3_req_drop", 32'(MBOX_REQ), 0);
    step(4); chk("t3_busy_nxm", 32'(BUSY), 1);
    step; chk("t3_busy_end", 32'(BUSY), 0);
    // page fail and data together: page fail wins
    go(1, 1, 23'o0000200, 0);
    q.push_back('{c0 + 4, K_PF});
    step; idle_in(); chk("t4_wr", 32'(MBOX_WR), 1); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0;
    step; MBOX_PF = 1'b1; MBOX_DATA_OK = 1'b1;
    step; MBOX_PF = 1'b0; MBOX_DATA_OK = 1'b0;
    step;
    // data on the last timeout cycle beats NXM
    go(1, 0, 23'o0000300, 0);
    q.push_back('{c0 + 6, K_DONE});
    step; idle_in(); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0;
    step(3); MBOX_DATA_OK = 1'b1;
    step; MBOX_DATA_OK = 1'b0;
    step;
    // fetch address break
    BRK_COND = 3'b100; MATCH = 1'b1; REQ_FETCH = 1'b1;
    go(1, 0, 23'o0000400, 0);
    q.push_back('{c0 + 1, K_TRAP});
    step; idle_in(); chk("t5_req", 32'(MBOX_REQ), 0);
    step; chk("t5_busy_end", 32'(BUSY), 0);
    // write break enable does not hit a fetch-read
    BRK_COND = 3'b001; MATCH = 1'b1; REQ_FETCH = 1'b1;
    go(1, 0, 23'o0000500, 0);
    q.push_back('{c0 + 3, K_DONE});
    step; idle_in(); chk("t5b_req", 32'(MBOX_REQ), 1); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0; MBOX_DATA_OK = 1'b1;
    step; MBOX_DATA_OK = 1'b0;
    step; BRK_COND = '0;
    // mid-WAIT START ignored, then reset aborts WAIT silently
    go(1, 0, 23'o1111111, 0);
    step; idle_in(); MBOX_ACK = 1'b1;
    step; MBOX_ACK = 1'b0;
    go(1, 0, 23'o2222222, 1);
    step; idle_in();
    chk("t6_addr_kept", 32'(MBOX_ADDR), 32'(23'o1111111));
    chk("t6_busy_wait", 32'(BUSY), 1);
    RESET = 1'b1;
    step; RESET = 1'b0;
    chk("t6_busy_rst", 32'(BUSY), 0);
    chk("t6_addr_rst", 32'(MBOX_ADDR), 0);
    // reset while requesting
    go(0, 1, 23'o0000600, 0);
    step; idle_in(); chk("t6_req_on", 32'(MBOX_REQ), 1); RESET = 1'b1;
    step; RESET = 1'b0;
    chk("t6_req_rst", 32'(MBOX_REQ), 0);
    chk("t6_busy_rst2", 32'(BUSY), 0);
    MBOX_DATA_OK = 1'b1;
    step; MBOX_DATA_OK = 1'b0;
    step(8);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
